// File: rtl/rf_pkg.sv
// Shared constants and types for the parametrised register file.
// Defaults match the fixed 16x32 file this design replaces.
package rf_pkg;

  localparam int unsigned RF_DATA_W = 32;
  localparam int unsigned RF_ADDR_W = 4;

  typedef logic [RF_ADDR_W-1:0] reg_addr_t;
  typedef logic [RF_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/rf_param_if.sv
// Datapath-side bundle of the register file: write port, two read ports,
// and the scoreboard claim/flush/busy signals.
interface rf_param_if
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W = RF_DATA_W,
  parameter int unsigned ADDR_W = RF_ADDR_W
);

  logic              WrEn;
  logic [ADDR_W-1:0] RD;
  logic [DATA_W-1:0] DIN;
  logic [ADDR_W-1:0] RS1;
  logic [ADDR_W-1:0] RS2;
  logic [DATA_W-1:0] OUT1;
  logic [DATA_W-1:0] OUT2;
  logic              Claim;
  logic [ADDR_W-1:0] ClaimAddr;
  logic              Flush;
  logic              Busy1;
  logic              Busy2;

  modport master (
    output WrEn, RD, DIN, RS1, RS2, Claim, ClaimAddr, Flush,
    input  OUT1, OUT2, Busy1, Busy2
  );

  modport slave (
    input  WrEn, RD, DIN, RS1, RS2, Claim, ClaimAddr, Flush,
    output OUT1, OUT2, Busy1, Busy2
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register pending bits. Within one edge: write-clear, then flush,
// then claim, so a new producer always wins.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned ADDR_W = RF_ADDR_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              claim,
  input  logic [ADDR_W-1:0] claim_addr,
  input  logic              flush,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic              busy1,
  output logic              busy2
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;

  always_comb begin
    busy_nxt = busy;
    if (wr_en) busy_nxt[wr_addr] = 1'b0;
    if (flush) busy_nxt = '0;
    if (claim) busy_nxt[claim_addr] = 1'b1;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) busy <= '0;
    else       busy <= busy_nxt;
  end

  assign busy1 = busy[rs1];
  assign busy2 = busy[rs2];

endmodule

// File: rtl/rf_param.sv
// Parametrised 2R/1W register file with write-to-read bypass, optional
// hardwired-zero r0 and a busy scoreboard for in-flight producers.
module rf_param
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W  = RF_DATA_W,
  parameter int unsigned ADDR_W  = RF_ADDR_W,
  parameter bit          ZERO_R0 = 1'b0,
  parameter bit          BYPASS  = 1'b1
) (
  input logic        CLK,
  input logic        RESET,
  rf_param_if.slave  bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];

  logic              wr_ok;
  logic              claim_ok;
  logic              rs1_zero;
  logic              rs2_zero;
  logic              sb_busy1;
  logic              sb_busy2;
  logic [DATA_W-1:0] out1;
  logic [DATA_W-1:0] out2;

  // Gating with RESET also suppresses bypass while reset is held, so the
  // outputs read 0 even if the parent keeps WrEn asserted.
  assign wr_ok    = bus.WrEn  && !RESET && !(ZERO_R0 && (bus.RD == '0));
  assign claim_ok = bus.Claim && !(ZERO_R0 && (bus.ClaimAddr == '0));
  assign rs1_zero = ZERO_R0 && (bus.RS1 == '0);
  assign rs2_zero = ZERO_R0 && (bus.RS2 == '0);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[bus.RD] <= bus.DIN;
    end
  end

  always_comb begin
    out1 = regs[bus.RS1];
    out2 = regs[bus.RS2];
    if (BYPASS && wr_ok && (bus.RS1 == bus.RD)) out1 = bus.DIN;
    if (BYPASS && wr_ok && (bus.RS2 == bus.RD)) out2 = bus.DIN;
    if (rs1_zero) out1 = '0;
    if (rs2_zero) out2 = '0;
  end

  assign bus.OUT1 = out1;
  assign bus.OUT2 = out2;

  rf_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_sb (
    .CLK        (CLK),
    .RESET      (RESET),
    .wr_en      (wr_ok),
    .wr_addr    (bus.RD),
    .claim      (claim_ok),
    .claim_addr (bus.ClaimAddr),
    .flush      (bus.Flush),
    .rs1        (bus.RS1),
    .rs2        (bus.RS2),
    .busy1      (sb_busy1),
    .busy2      (sb_busy2)
  );

  assign bus.Busy1 = sb_busy1 && !rs1_zero;
  assign bus.Busy2 = sb_busy2 && !rs2_zero;

endmodule

// File: tb/tb_rf_param.sv
// Bench for rf_param: instance A (ZERO_R0=0, BYPASS=1) and instance B
// (ZERO_R0=1, BYPASS=0) driven with identical stimulus.
module tb_rf_param;
  import rf_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic      wren = 1'b0;
  reg_addr_t rd = '0;
  reg_data_t din = '0;
  reg_addr_t rs1 = '0;
  reg_addr_t rs2 = '0;
  logic      claim = 1'b0;
  reg_addr_t caddr = '0;
  logic      flush = 1'b0;

  rf_param_if #(.DATA_W(32), .ADDR_W(4)) ifa ();
  rf_param_if #(.DATA_W(32), .ADDR_W(4)) ifb ();

  assign ifa.WrEn = wren;  assign ifb.WrEn = wren;
  assign ifa.RD   = rd;    assign ifb.RD   = rd;
  assign ifa.DIN  = din;   assign ifb.DIN  = din;
  assign ifa.RS1  = rs1;   assign ifb.RS1  = rs1;
  assign ifa.RS2  = rs2;   assign ifb.RS2  = rs2;
  assign ifa.Claim = claim;     assign ifb.Claim = claim;
  assign ifa.ClaimAddr = caddr; assign ifb.ClaimAddr = caddr;
  assign ifa.Flush = flush;     assign ifb.Flush = flush;

  rf_param #(.DATA_W(32), .ADDR_W(4), .ZERO_R0(1'b0), .BYPASS(1'b1))
    dut_a (.CLK(clk), .RESET(rst), .bus(ifa));
  rf_param #(.DATA_W(32), .ADDR_W(4), .ZERO_R0(1'b1), .BYPASS(1'b0))
    dut_b (.CLK(clk), .RESET(rst), .bus(ifb));

  int unsigned tests = 0;
  int unsigned fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Outputs are sampled on the falling edge, away from the active edge.
  task automatic settle();
    @(negedge clk);
  endtask

  typedef struct {
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [31:0] a1;
    logic [31:0] a2;
    logic [31:0] b1;
    logic [31:0] b2;
  } vec_t;

  logic [31:0] fib [16];
  vec_t        tbl [16];

  initial begin
    fib = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 16; i++) begin
      tbl[i].rs1 = 4'(i);
      tbl[i].rs2 = 4'(15 - i);
      tbl[i].a1  = fib[i];
      tbl[i].a2  = fib[15 - i];
      tbl[i].b1  = (i == 0) ? 32'd0 : fib[i];
      tbl[i].b2  = (i == 15) ? 32'd0 : fib[15 - i];
    end

    // Reset state sweep
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rs1 = 4'(i); rs2 = 4'(i);
      settle();
      chk("rst_a_out1", ifa.OUT1, 0); chk("rst_a_out2", ifa.OUT2, 0);
      chk("rst_b_out1", ifb.OUT1, 0);
      chk("rst_a_busy", {30'd0, ifa.Busy1, ifa.Busy2}, 0);
      chk("rst_b_busy", {30'd0, ifb.Busy1, ifb.Busy2}, 0);
    end

    // WrEn=0 must not write
    rd = 4'd0; din = 32'd42; wren = 1'b0; rs1 = 4'd0;
    step(); settle();
    chk("nowr_a_r0", ifa.OUT1, 0);

    // Fibonacci load r0..r8
    @(posedge clk); #1;
    for (int i = 0; i < 9; i++) begin
      wren = 1'b1; rd = 4'(i); din = fib[i];
      step();
    end
    wren = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rs1 = tbl[i].rs1; rs2 = tbl[i].rs2;
      settle();
      chk($sformatf("sweep_a1_r%0d", tbl[i].rs1), ifa.OUT1, tbl[i].a1);
      chk($sformatf("sweep_a2_r%0d", tbl[i].rs2), ifa.OUT2, tbl[i].a2);
      chk($sformatf("sweep_b1_r%0d", tbl[i].rs1), ifb.OUT1, tbl[i].b1);
      chk($sformatf("sweep_b2_r%0d", tbl[i].rs2), ifb.OUT2, tbl[i].b2);
    end

    // Bypass vs. no bypass
    @(posedge clk); #1;
    wren = 1'b1; rd = 4'd5; din = 32'd77; rs1 = 4'd5; rs2 = 4'd5;
    settle();
    chk("byp_a_out1", ifa.OUT1, 77);
    chk("byp_a_out2", ifa.OUT2, 77);
    chk("nobyp_b_out1", ifb.OUT1, 8);
    step(); wren = 1'b0; settle();
    chk("post_a_out1", ifa.OUT1, 77);
    chk("post_b_out1", ifb.OUT1, 77);

    // Claim, write-clear, claim+write same edge
    @(posedge clk); #1;
    claim = 1'b1; caddr = 4'd3; rs1 = 4'd3;
    settle();
    chk("preclaim_busy", ifa.Busy1, 0);
    step(); claim = 1'b0; settle();
    chk("claim_a_busy", ifa.Busy1, 1);
    chk("claim_b_busy", ifb.Busy1, 1);
    @(posedge clk); #1;
    wren = 1'b1; rd = 4'd3; din = 32'd9;
    settle();
    chk("wr_prebusy", ifa.Busy1, 1);
    step(); wren = 1'b0; settle();
    chk("wrclr_busy", ifa.Busy1, 0);
    chk("wrclr_out1", ifa.OUT1, 9);
    chk("wrclr_b_out1", ifb.OUT1, 9);
    @(posedge clk); #1;
    wren = 1'b1; rd = 4'd3; din = 32'd100; claim = 1'b1; caddr = 4'd3;
    step(); wren = 1'b0; claim = 1'b0; settle();
    chk("clwr_busy", ifa.Busy1, 1);
    chk("clwr_out1", ifa.OUT1, 100);
    chk("clwr_b_out1", ifb.OUT1, 100);

    // Claim on r0: honoured in A, dropped in B
    @(posedge clk); #1;
    claim = 1'b1; caddr = 4'd0; rs2 = 4'd0;
    step(); claim = 1'b0; settle();
    chk("r0claim_a", ifa.Busy2, 1);
    chk("r0claim_b", ifb.Busy2, 0);

    // Claims r2,r4,r6 then flush with claim r7
    @(posedge clk); #1;
    claim = 1'b1;
    caddr = 4'd2; step();
    caddr = 4'd4; step();
    caddr = 4'd6; step();
    claim = 1'b0;
    rs1 = 4'd4; rs2 = 4'd6; settle();
    chk("pre_flush_r4", ifa.Busy1, 1);
    chk("pre_flush_r6", ifa.Busy2, 1);
    @(posedge clk); #1;
    flush = 1'b1; claim = 1'b1; caddr = 4'd7;
    step(); flush = 1'b0; claim = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rs1 = 4'(i); rs2 = 4'(i);
      settle();
      chk($sformatf("flush_a_r%0d", i), ifa.Busy1, (i == 7) ? 1 : 0);
      chk($sformatf("flush_b_r%0d", i), ifb.Busy2, (i == 7) ? 1 : 0);
    end

    // Async reset mid-cycle with data and busy bits live
    @(posedge clk); #1;
    rs1 = 4'd5; rs2 = 4'd7;
    settle();
    chk("prerst_out1", ifa.OUT1, 77);
    chk("prerst_busy2", ifa.Busy2, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_a_out1", ifa.OUT1, 0);
    chk("arst_b_out1", ifb.OUT1, 0);
    chk("arst_busy2", ifa.Busy2, 0);
    wren = 1'b1; rd = 4'd5; din = 32'd55; claim = 1'b1; caddr = 4'd5;
    #1;
    chk("arst_byp_out1", ifa.OUT1, 0);
    step(); settle();
    chk("rstwr_out1", ifa.OUT1, 0);
    chk("rstwr_busy1", ifa.Busy1, 0);
    wren = 1'b0; claim = 1'b0; rst = 1'b0;
    step(); settle();
    chk("postrst_a_out1", ifa.OUT1, 0);
    chk("postrst_b_out1", ifb.OUT1, 0);
    chk("postrst_busy1", ifa.Busy1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rf_param.md
# rf_param

Parametrised register file with a per-register pending (scoreboard) bit, the next generation of the fixed 16×32 two-read/one-write file. It sits in the CPU datapath between decode and writeback. It adds four things to its predecessor: configurable width and depth, optional hardwired-zero r0, same-cycle write-to-read bypass, and busy tracking for in-flight producers. Clear-on-reset and a flush input return it to a clean state.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 4, address width; depth = 2**ADDR_W
- ZERO_R0, 0, 1 = r0 reads as 0, ignores writes and claims
- BYPASS, 1, 1 = read ports return DIN when reading the register written this cycle

Ports:
- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-high; clears all registers and busy bits
- WrEn  in  1  write enable
- RD  in  ADDR_W  write address
- DIN  in  DATA_W  write data
- RS1  in  ADDR_W  read address, port 1
- RS2  in  ADDR_W  read address, port 2
- OUT1  out  DATA_W  read data, port 1
- OUT2  out  DATA_W  read data, port 2
- Claim  in  1  mark register ClaimAddr as pending
- ClaimAddr  in  ADDR_W  register to mark pending
- Flush  in  1  clear all busy bits
- Busy1  out  1  pending status of RS1
- Busy2  out  1  pending status of RS2

## Operation
- Storage: 2**ADDR_W × DATA_W registers, plus one busy bit per register.
- Write: at the rising edge with WrEn=1, regs[RD] <= DIN and busy[RD] <= 0.
- Read: OUT1/OUT2 are combinational from RS1/RS2.
- Bypass (BYPASS=1): if WrEn=1 and RS==RD, OUT = DIN in the same cycle.
- With BYPASS=0, OUT shows the old value until the edge.
- Busy1/Busy2 are combinational from busy[RS1]/busy[RS2]. Reads return data regardless of busy; the consumer stalls.
- Claim: at the edge with Claim=1, busy[ClaimAddr] <= 1.
- Flush: at the edge with Flush=1, all busy bits <= 0.
- Precedence within one edge, lowest to highest: write-clear, then flush, then claim.
  - Claim and write to the same address: busy ends 1 (new producer) and data is still written.
  - Flush and claim together: only the claimed bit ends 1.
- Bypass does not affect Busy; Busy shows the pre-edge state.
- ZERO_R0=1:
  - Writes to r0 are dropped.
  - OUT reads of r0 return 0, with no bypass.
  - Claims on r0 are dropped; Busy for r0 is always 0.
- RESET asserted:
  - Immediately, without waiting for CLK, all regs = 0 and all busy = 0.
  - The write, claim and flush of any edge while RESET=1 are ignored.
- Address arithmetic is unsigned ADDR_W; no wrap or out-of-range case exists.

## Timing
- Reset values: OUT1 = OUT2 = 0 and Busy1 = Busy2 = 0 for any RS.
- Write latency:
  - Data visible through storage on the cycle after the edge.
  - Visible the same cycle via bypass when BYPASS=1.
- Claim/Flush latency: Busy reflects the change on the cycle after the edge.
- Read latency: zero cycles, combinational.
- RESET deassertion is taken synchronously to CLK by the parent. The first active edge is the first rising edge with RESET=0.
- RESET mid-operation: in-flight claims are lost; the parent must also flush its pipeline.

## Structure
- Shared package rf_pkg:
  - default DATA_W and ADDR_W constants
  - typedefs reg_addr_t and reg_data_t
- Sub-module rf_scoreboard holds the busy vector with its claim/flush/write-clear precedence and async reset. It exposes busy[RS1] and busy[RS2].
- Top level rf_param holds the data array, the bypass muxes and the ZERO_R0 gating.

## Test plan
- Reset, then sweep RS1 = RS2 = 0..15 -> all OUT = 0 and all Busy = 0. Write 42 to r0 with WrEn=0 -> r0 still reads 0.
- Write the sequence 1,1,2,3,5,8,13,21,34 to r0..r8 over consecutive edges, then sweep -> r0..r8 read those values and r9..r15 read 0. Repeat with ZERO_R0=1 -> r0 reads 0.
- Bypass check: WrEn=1, RD=5, DIN=77, RS1=5, before the edge:
  - BYPASS=1 -> OUT1 = 77.
  - BYPASS=0 -> OUT1 keeps the old value (8), then reads 77 after the edge.
- Claim r3; next cycle Busy1 (RS1=3) = 1. Write r3=9 -> Busy1 = 0 next cycle and OUT1 = 9. Claim and write r3 in the same edge -> Busy1 = 1 and OUT1 = new data.
- Claim r2, r4, r6 on successive edges, then Flush together with a claim on r7 -> only r7 busy.
- Assert RESET asynchronously mid-cycle with registers loaded and busy bits set -> OUT and Busy go to 0 before the next CLK edge; a write edge during RESET is ignored.
